// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, picks the next PC (sequential, branch or jump), latches the fetched
// instruction and its PC+4 into IF/ID, and keeps saturating stall/flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PcWrite,
    input  logic              IF_ID_Write,
    input  logic              Branch,
    input  logic [31:0]       BranchTarget,
    input  logic              Jump,
    input  logic [31:0]       JumpTarget,
    input  logic [31:0]       InstIn,
    output logic [31:0]       PcOut,
    output logic [31:0]       IF_ID_Inst,
    output logic [31:0]       IF_ID_PcPlus4,
    output logic              IF_ID_Valid,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pp4_q, pp4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             redir;

    // Sequential PC wraps modulo 2^32; a redirect only counts when the PC may move.
    assign pc_plus4 = pc_q + 32'd4;
    assign redir    = PcWrite & (Jump | Branch);

    // Next PC: hold on stall, otherwise jump beats branch beats sequential.
    always_comb begin
        pc_d = pc_q;
        if (PcWrite) begin
            if (Jump) begin
                pc_d = JumpTarget;
            end else if (Branch) begin
                pc_d = BranchTarget;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // Next IF/ID contents: a flush overrides the hold, so the wrong-path fetch never lands.
    always_comb begin
        inst_d  = inst_q;
        pp4_d   = pp4_q;
        valid_d = valid_q;
        if (redir) begin
            inst_d  = NOP_INST;
            pp4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (IF_ID_Write) begin
            inst_d  = InstIn;
            pp4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // Next counter values, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!PcWrite && (stall_q != CntMax)) begin
            stall_d = stall_q + CntOne;
        end
        if (redir && (flush_q != CntMax)) begin
            flush_d = flush_q + CntOne;
        end
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pp4_q   <= 32'd0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pp4_q   <= pp4_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign PcOut         = pc_q;
    assign IF_ID_Inst    = inst_q;
    assign IF_ID_PcPlus4 = pp4_q;
    assign IF_ID_Valid   = valid_q;
    assign StallCount    = stall_q;
    assign FlushCount    = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, a reference model checked every cycle,
// and literal expectations at key points. A second instance with 2-bit counters
// exercises saturation under the same stimulus.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, PcWrite, IF_ID_Write, Branch, Jump;
    logic [31:0] BranchTarget, JumpTarget, InstIn;

    logic [31:0] PcOut, IF_ID_Inst, IF_ID_PcPlus4;
    logic        IF_ID_Valid;
    logic [15:0] StallCount, FlushCount;

    logic [31:0] sPcOut, sInst, sPp4;
    logic        sValid;
    logic [1:0]  sStall, sFlush;

    int tests  = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    // Model state
    logic [31:0] mPc, mInst, mPp4;
    logic        mValid;
    int          mStall16, mFlush16, mStall2, mFlush2;

    always #5 clk = ~clk;

    // Combinational instruction memory: a PC-derived word, never zero at PC 0.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h2400_0000;
    endfunction

    assign InstIn = memWord(PcOut);

    fetch_stage dut (
        .clk(clk), .rst(rst), .PcWrite(PcWrite), .IF_ID_Write(IF_ID_Write),
        .Branch(Branch), .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .InstIn(InstIn), .PcOut(PcOut), .IF_ID_Inst(IF_ID_Inst), .IF_ID_PcPlus4(IF_ID_PcPlus4),
        .IF_ID_Valid(IF_ID_Valid), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    fetch_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .PcWrite(PcWrite), .IF_ID_Write(IF_ID_Write),
        .Branch(Branch), .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .InstIn(InstIn), .PcOut(sPcOut), .IF_ID_Inst(sInst), .IF_ID_PcPlus4(sPp4),
        .IF_ID_Valid(sValid), .StallCount(sStall), .FlushCount(sFlush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satInc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Reference model: architectural rules applied once per rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mPc = 32'h0; mInst = 32'h0; mPp4 = 32'h0; mValid = 1'b0;
            mStall16 = 0; mFlush16 = 0; mStall2 = 0; mFlush2 = 0;
        end else begin
            logic        taken;
            logic [31:0] target;
            logic [31:0] seq;
            taken  = PcWrite && (Jump || Branch);
            target = Jump ? JumpTarget : BranchTarget;
            seq    = mPc + 32'd4;
            if (taken) begin
                mInst = 32'h0; mPp4 = 32'h0; mValid = 1'b0;
            end else if (IF_ID_Write) begin
                mInst = memWord(mPc); mPp4 = seq; mValid = 1'b1;
            end
            if (!PcWrite) begin
                mStall16 = satInc(mStall16, 65535);
                mStall2  = satInc(mStall2, 3);
            end
            if (taken) begin
                mFlush16 = satInc(mFlush16, 65535);
                mFlush2  = satInc(mFlush2, 3);
            end
            if (PcWrite) mPc = taken ? target : seq;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chkEn) begin
            check("pc", PcOut, mPc);
            check("inst", IF_ID_Inst, mInst);
            check("pp4", IF_ID_PcPlus4, mPp4);
            check("valid", 32'(IF_ID_Valid), 32'(mValid));
            check("stall16", 32'(StallCount), mStall16);
            check("flush16", 32'(FlushCount), mFlush16);
            check("sat_pc", sPcOut, mPc);
            check("sat_stall", 32'(sStall), mStall2);
            check("sat_flush", 32'(sFlush), mFlush2);
        end
    end

    task automatic step(input logic r, input logic pw, input logic iw, input logic br,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt);
        rst = r; PcWrite = pw; IF_ID_Write = iw;
        Branch = br; BranchTarget = bt; Jump = j; JumpTarget = jt;
        @(posedge clk);
        #1;
    endtask

    task automatic run();  step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0); endtask
    task automatic stall(); step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); endtask

    task automatic checkReset(input string tag);
        check({tag, "_pc"}, PcOut, 32'h0);
        check({tag, "_inst"}, IF_ID_Inst, 32'h0);
        check({tag, "_pp4"}, IF_ID_PcPlus4, 32'h0);
        check({tag, "_valid"}, 32'(IF_ID_Valid), 32'h0);
        check({tag, "_stall"}, 32'(StallCount), 32'h0);
        check({tag, "_flush"}, 32'(FlushCount), 32'h0);
        check({tag, "_sstall"}, 32'(sStall), 32'h0);
    endtask

    initial begin
        logic [1:0] satExp [5];
        satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1; PcWrite = 1'b0; IF_ID_Write = 1'b0;
        Branch = 1'b0; Jump = 1'b0; BranchTarget = 32'h0; JumpTarget = 32'h0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chkEn = 1'b1;
        checkReset("rst0");

        // Sequential fetch
        run();
        check("seq1_pc", PcOut, 32'h4);
        check("seq1_valid", 32'(IF_ID_Valid), 32'h1);
        check("seq1_pp4", IF_ID_PcPlus4, 32'h4);
        check("seq1_inst", IF_ID_Inst, 32'h2400_0000);
        run();
        check("seq2_pc", PcOut, 32'h8);
        check("seq2_inst", IF_ID_Inst, 32'h2400_0004);

        // Two-cycle stall at PC 8
        stall();
        stall();
        check("stall_pc", PcOut, 32'h8);
        check("stall_pp4", IF_ID_PcPlus4, 32'h8);
        check("stall_inst", IF_ID_Inst, 32'h2400_0004);
        check("stall_cnt", 32'(StallCount), 32'd2);
        run();
        check("resume_pc", PcOut, 32'hC);
        check("resume_inst", IF_ID_Inst, 32'h2400_0008);
        run();
        check("pre_br_pc", PcOut, 32'h10);

        // Taken branch: one bubble
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        check("br_pc", PcOut, 32'h40);
        check("br_valid", 32'(IF_ID_Valid), 32'h0);
        check("br_inst", IF_ID_Inst, 32'h0);
        check("br_flush", 32'(FlushCount), 32'd1);
        run();
        check("br_tgt_pp4", IF_ID_PcPlus4, 32'h44);
        check("br_tgt_valid", 32'(IF_ID_Valid), 32'h1);
        check("br_tgt_inst", IF_ID_Inst, 32'h2400_0040);

        // Jump beats branch
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        check("jmp_pc", PcOut, 32'h80);
        check("jmp_flush", 32'(FlushCount), 32'd2);

        // Branch while stalled is ignored
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("stbr_pc", PcOut, 32'h80);
        check("stbr_flush", 32'(FlushCount), 32'd2);
        check("stbr_stall", 32'(StallCount), 32'd3);
        run();
        check("post_pc", PcOut, 32'h84);

        // Flush wins over IF_ID_Write=0
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
        check("fl_pc", PcOut, 32'h200);
        check("fl_valid", 32'(IF_ID_Valid), 32'h0);
        check("fl_flush", 32'(FlushCount), 32'd3);

        // Mismatched enables: PC holds, IF/ID loads
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("mm_pc", PcOut, 32'h200);
        check("mm_pp4", IF_ID_PcPlus4, 32'h204);
        check("mm_inst", IF_ID_Inst, 32'h2400_0200);
        check("mm_sstall", 32'(sStall), 32'd3);

        // PC wrap through 0xFFFFFFFC
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        check("wrapj_pc", PcOut, 32'hFFFF_FFFC);
        check("wrapj_sflush", 32'(sFlush), 32'd3);
        check("wrapj_flush", 32'(FlushCount), 32'd4);
        run();
        check("wrap_pc", PcOut, 32'h0);
        check("wrap_pp4", IF_ID_PcPlus4, 32'h0);
        check("wrap_inst", IF_ID_Inst, 32'hDBFF_FFFC);

        // Reset, then saturation of the 2-bit stall counter
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkReset("rst1");
        for (int i = 0; i < 5; i++) begin
            stall();
            check($sformatf("sat%0d", i), 32'(sStall), 32'(satExp[i]));
            check($sformatf("cnt%0d", i), 32'(StallCount), i + 1);
        end

        // Reset during a redirect discards it
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        checkReset("rst2");
        check("rst2_sflush", 32'(sFlush), 32'h0);

        @(negedge clk);
        chkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC: PC+4, branch target or jump target.
- Latches instruction and PC+4 into IF/ID, with stall, flush and valid tracking.
- Directly consumes the hazard unit's PcWrite/IF_ID_Write and the ID-stage redirect, and feeds the ID stage.
- Also keeps saturating stall and flush counters for performance debug.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0)
CNT_W, 16, width of the StallCount and FlushCount counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
PcWrite  input  1  from hazard unit; 1 = PC may update, 0 = hold PC
IF_ID_Write  input  1  from hazard unit; 1 = IF/ID may load, 0 = hold IF/ID
Branch  input  1  ID stage: branch resolved taken this cycle
BranchTarget  input  32  ID stage branch target address
Jump  input  1  ID stage: jump this cycle
JumpTarget  input  32  ID stage jump target address
InstIn  input  32  instruction-memory read data for address PcOut (combinational memory)
PcOut  output  32  current PC, instruction-memory address
IF_ID_Inst  output  32  registered instruction to ID
IF_ID_PcPlus4  output  32  registered PC+4 of that instruction
IF_ID_Valid  output  1  1 = IF_ID_Inst is a real fetched instruction; 0 = bubble
StallCount  output  CNT_W  cycles with PcWrite=0, saturating
FlushCount  output  CNT_W  accepted redirects, saturating

Behaviour:
- All state updates on rising clk. rst is sampled synchronously and overrides every other input.
- Reset values:
  - PcOut = RESET_PC
  - IF_ID_Inst = NOP_INST
  - IF_ID_PcPlus4 = 0
  - IF_ID_Valid = 0
  - StallCount = 0
  - FlushCount = 0
- PcPlus4 = PcOut + 32'd4, modulo 2^32. PC 32'hFFFFFFFC wraps to 0; no special handling.
- Redirect: redir = PcWrite & (Jump | Branch).
  - Jump has priority over Branch when both are 1.
  - Branch/Jump with PcWrite=0 are ignored. The hazard unit is stalling for branch operands, so ID re-evaluates next cycle.
- PC update, in priority order:
  1. rst → RESET_PC.
  2. PcWrite=0 → hold.
  3. Jump → JumpTarget.
  4. Branch → BranchTarget.
  5. Otherwise → PcPlus4.
- IF/ID update, in priority order:
  1. rst → bubble.
  2. redir → bubble (flush). This wins even if IF_ID_Write=0.
  3. IF_ID_Write=0 → hold all three fields unchanged.
  4. Otherwise → IF_ID_Inst=InstIn, IF_ID_PcPlus4=PcPlus4, IF_ID_Valid=1.
- Bubble means IF_ID_Inst=NOP_INST, IF_ID_PcPlus4=0, IF_ID_Valid=0.
- Latency:
  - An instruction at PcOut in cycle n appears on IF_ID_* in cycle n+1.
  - A redirect accepted in cycle n gives PcOut=target in n+1 and a bubble in IF/ID in n+1.
  - The target instruction reaches IF/ID in n+2, so there is one bubble per taken branch/jump.
- Stall pairing: the hazard unit drives PcWrite and IF_ID_Write together. Mismatched values are still legal and each register obeys only its own enable.
- Counters:
  - StallCount += 1 each non-reset cycle with PcWrite=0.
  - FlushCount += 1 each non-reset cycle with redir=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Cleared only by rst.
- Reset mid-stall or mid-redirect: rst wins. Next cycle PcOut=RESET_PC, a bubble is in IF/ID, and the pending redirect is discarded.
- The block contains no combinational path from inputs to PcOut; PcOut is a pure register.

Test Plan:
- Reset, then rst=0, PcWrite=IF_ID_Write=1, InstIn=PC-derived words for 3 cycles:
  - PcOut steps 0→4→8→C.
  - IF_ID_Valid is 0 in cycle 1, then 1 from cycle 2.
  - IF_ID_PcPlus4 steps 4, 8, C.
- Stall: at PcOut=8, hold PcWrite=IF_ID_Write=0 for 2 cycles.
  - PcOut stays 8 and IF_ID_Inst/IF_ID_PcPlus4 stay unchanged.
  - StallCount increases by 2; the fetch from 8 resumes afterwards.
- Taken branch: at PcOut=10, Branch=1, BranchTarget=40.
  - Next cycle: PcOut=40, IF_ID_Valid=0, IF_ID_Inst=0, FlushCount=1.
  - Following cycle: IF_ID_PcPlus4=44, IF_ID_Valid=1.
- Branch=1, Jump=1, BranchTarget=40, JumpTarget=80 → PcOut=80 next cycle. Then Branch=1 with PcWrite=0 → PC held, FlushCount unchanged.
- Redirect with IF_ID_Write=0, PcWrite=1 → flush wins: IF_ID_Valid=0 and PcOut=target.
- CNT_W=2, hold PcWrite=0 for 5 cycles → StallCount 1, 2, 3, 3, 3. Then rst=1 for one cycle → all outputs at their reset values, with PcOut=RESET_PC.
